// File: rtl/risc8_regs_pkg.sv
// Shared encodings for the multi-port 8-bit register file: per-byte read
// source selects and the clear/run sequencer states.
package risc8_regs_pkg;

  typedef enum logic [2:0] {
    SRC_RAM_LO = 3'd0,
    SRC_RAM_HI = 3'd1,
    SRC_BYP_LO = 3'd2,
    SRC_BYP_HI = 3'd3,
    SRC_ZERO   = 3'd4
  } src_e;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  // A byte write always forwards the low half of Rd, whatever its byte index.
  function automatic src_e byte_src(input logic idx, input logic hit, input logic word_wr);
    if (hit) return (word_wr && idx) ? SRC_BYP_HI : SRC_BYP_LO;
    return idx ? SRC_RAM_HI : SRC_RAM_LO;
  endfunction

endpackage

// File: rtl/risc8_regs_bank.sv
// One word-wide synchronous RAM bank with per-byte write enables and a
// registered read port.
module risc8_regs_bank #(
  parameter int DW    = 8,
  parameter int WORDS = 16,
  parameter int WAW   = $clog2(WORDS)
) (
  input  logic            clk,
  input  logic [1:0]      we,
  input  logic [WAW-1:0]  waddr,
  input  logic [2*DW-1:0] wdata,
  input  logic [WAW-1:0]  raddr,
  output logic [2*DW-1:0] rdata
);

  logic [2*DW-1:0] mem [WORDS];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (we[i]) mem[waddr][i*DW +: DW] <= wdata[i*DW +: DW];
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/risc8_regs_mp.sv
// Multi-port register file: one pair-capable A port and NB byte B ports over
// duplicated RAM banks, with write bypass and a self-clearing start-up.
module risc8_regs_mp
  import risc8_regs_pkg::*;
#(
  parameter int DW    = 8,
  parameter int NREGS = 32,
  parameter int NB    = 1,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [AW-1:0]   a,
  input  logic [NB*AW-1:0] b,
  output logic [2*DW-1:0] Ra,
  output logic [NB*DW-1:0] Rb,
  input  logic            write,
  input  logic            write_word,
  input  logic [AW-1:0]   d,
  input  logic [2*DW-1:0] Rd,
  output logic            ready
);

  localparam int WAW   = AW - 1;
  localparam int WORDS = NREGS / 2;

  state_e          state, state_nx;
  logic [WAW-1:0]  clr_cnt, clr_cnt_nx;
  logic            run_wr;
  logic [1:0]      bank_we;
  logic [WAW-1:0]  bank_waddr;
  logic [2*DW-1:0] bank_wdata;
  logic [WAW-1:0]  bank_raddr [NB+1];
  logic [2*DW-1:0] bank_rdata [NB+1];
  logic [2*DW-1:0] rd_hold;
  src_e            sel_a_lo, sel_a_hi, sel_a_lo_nx, sel_a_hi_nx;
  src_e            sel_b [NB];
  src_e            sel_b_nx [NB];

  function automatic logic wr_hit(input logic en, input logic ww,
                                  input logic [AW-1:0] wa, input logic [AW-1:0] ra);
    return en && (wa[AW-1:1] == ra[AW-1:1]) && (ww || (wa[0] == ra[0]));
  endfunction

  function automatic logic [DW-1:0] pick(input src_e s, input logic [2*DW-1:0] ram,
                                         input logic [2*DW-1:0] hold);
    case (s)
      SRC_RAM_LO: return ram[DW-1:0];
      SRC_RAM_HI: return ram[2*DW-1:DW];
      SRC_BYP_LO: return hold[DW-1:0];
      SRC_BYP_HI: return hold[2*DW-1:DW];
      default:    return '0;
    endcase
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_CLEAR;
      clr_cnt <= '0;
    end else begin
      state   <= state_nx;
      clr_cnt <= clr_cnt_nx;
    end
  end

  // Clearing owns the write port; reset also blocks RAM writes so a collision drops the write.
  always_comb begin
    state_nx   = state;
    clr_cnt_nx = clr_cnt;
    run_wr     = 1'b0;
    bank_we    = 2'b00;
    bank_waddr = d[AW-1:1];
    bank_wdata = Rd;
    case (state)
      ST_CLEAR: begin
        bank_we    = 2'b11;
        bank_waddr = clr_cnt;
        bank_wdata = '0;
        clr_cnt_nx = clr_cnt + WAW'(1);
        if (clr_cnt == WAW'(WORDS - 1)) begin
          state_nx   = ST_RUN;
          clr_cnt_nx = '0;
        end
      end
      default: begin
        run_wr = write;
        if (write) begin
          bank_we    = write_word ? 2'b11 : (d[0] ? 2'b10 : 2'b01);
          bank_wdata = write_word ? Rd : {2{Rd[DW-1:0]}};
        end
      end
    endcase
    if (!reset) bank_we = 2'b00;
  end

  always_comb begin
    sel_a_lo_nx = SRC_ZERO;
    sel_a_hi_nx = SRC_ZERO;
    for (int i = 0; i < NB; i++) sel_b_nx[i] = SRC_ZERO;
    if (state == ST_RUN) begin
      sel_a_lo_nx = byte_src(a[0], wr_hit(run_wr, write_word, d, a), write_word);
      sel_a_hi_nx = byte_src(~a[0], wr_hit(run_wr, write_word, d, {a[AW-1:1], ~a[0]}),
                             write_word);
      for (int i = 0; i < NB; i++) begin
        sel_b_nx[i] = byte_src(b[i*AW], wr_hit(run_wr, write_word, d, b[i*AW +: AW]),
                               write_word);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sel_a_lo <= SRC_ZERO;
      sel_a_hi <= SRC_ZERO;
      for (int i = 0; i < NB; i++) sel_b[i] <= SRC_ZERO;
      rd_hold  <= '0;
    end else begin
      sel_a_lo <= sel_a_lo_nx;
      sel_a_hi <= sel_a_hi_nx;
      for (int i = 0; i < NB; i++) sel_b[i] <= sel_b_nx[i];
      if (run_wr) rd_hold <= Rd;
    end
  end

  assign bank_raddr[0] = a[AW-1:1];

  genvar g;
  generate
    for (g = 0; g < NB; g++) begin : g_braddr
      assign bank_raddr[g+1] = b[g*AW+1 +: WAW];
      assign Rb[g*DW +: DW]  = pick(sel_b[g], bank_rdata[g+1], rd_hold);
    end
    for (g = 0; g <= NB; g++) begin : g_bank
      risc8_regs_bank #(.DW(DW), .WORDS(WORDS), .WAW(WAW)) u_bank (
        .clk   (clk),
        .we    (bank_we),
        .waddr (bank_waddr),
        .wdata (bank_wdata),
        .raddr (bank_raddr[g]),
        .rdata (bank_rdata[g])
      );
    end
  endgenerate

  assign Ra    = {pick(sel_a_hi, bank_rdata[0], rd_hold), pick(sel_a_lo, bank_rdata[0], rd_hold)};
  assign ready = (state == ST_RUN);

endmodule
